// File: rtl/seq_divider_if.sv
// Start/done handshake and result bundle between the ALU sequencer and seq_divider.
// The master issues operands; the slave (the divider) returns busy/done and held results.
interface seq_divider_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider: one trial subtraction per clock, WIDTH steps.
// Results are registered on entry to DONE and held until the next DONE or reset.
module seq_divider #(
    parameter int unsigned WIDTH = 8
) (
    input logic          clk,
    input logic          rst,
    seq_divider_if.slave bus
);
    localparam int unsigned CntW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH:0]   prem_q, prem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] quo_out_q, quo_out_d;
    logic [WIDTH-1:0] rem_out_q, rem_out_d;
    logic             dbz_q, dbz_d;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;

    always_comb begin
        state_d   = state_q;
        prem_d    = prem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        cnt_d     = cnt_q;
        quo_out_d = quo_out_q;
        rem_out_d = rem_out_q;
        dbz_d     = dbz_q;
        // Partial remainder stays below the divisor, so its top bit is free for the shift.
        shifted   = {prem_q[WIDTH-1:0], quo_q[WIDTH-1]};
        trial     = shifted - {1'b0, dvs_q};

        unique case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (bus.start) begin
                    if (bus.divisor == '0) begin
                        state_d   = StDone;
                        quo_out_d = '1;
                        rem_out_d = bus.dividend;
                        dbz_d     = 1'b1;
                    end else begin
                        state_d = StRun;
                        prem_d  = '0;
                        quo_d   = bus.dividend;
                        dvs_d   = bus.divisor;
                        cnt_d   = CntW'(WIDTH);
                    end
                end
            end
            StRun: begin
                prem_d = trial[WIDTH] ? shifted : trial;
                quo_d  = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == CntW'(1)) begin
                    state_d   = StDone;
                    quo_out_d = quo_d;
                    rem_out_d = prem_d[WIDTH-1:0];
                    dbz_d     = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            prem_q    <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            cnt_q     <= '0;
            quo_out_q <= '0;
            rem_out_q <= '0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            prem_q    <= prem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            cnt_q     <= cnt_d;
            quo_out_q <= quo_out_d;
            rem_out_q <= rem_out_d;
            dbz_q     <= dbz_d;
        end
    end

    assign bus.busy        = (state_q == StRun);
    assign bus.done        = (state_q == StDone);
    assign bus.quotient    = quo_out_q;
    assign bus.remainder   = rem_out_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed scenarios plus a randomized sweep
// compared against plain integer division.
module tb_seq_divider;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned MaxEdges = 40;

    logic clk = 1'b0;
    logic rst;
    int   passed = 0;
    int   total = 0;

    always #5 clk = ~clk;

    seq_divider_if #(.WIDTH(WIDTH)) bus ();

    seq_divider #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic int ref_q(input int a, input int b);
        return (b == 0) ? (1 << WIDTH) - 1 : a / b;
    endfunction

    function automatic int ref_r(input int a, input int b);
        return (b == 0) ? a : a % b;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation and return edges until done (accepting edge counts as 1).
    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          output int lat, output int busy_cycles);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        lat          = 0;
        busy_cycles  = 0;
        do begin
            tick();
            lat++;
            if (lat == 1) begin
                bus.start    = 1'b0;
                bus.dividend = WIDTH'($urandom);
                bus.divisor  = WIDTH'($urandom);
            end
            if (bus.busy === 1'b1) busy_cycles++;
        end while (bus.done !== 1'b1 && lat < MaxEdges);
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        bus.start    = 1'b1;
        bus.dividend = 8'd5;
        bus.divisor  = 8'd1;
        tick();
        tick();
        total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.busy); else passed++;
        total++; if (bus.done !== 1'b0) $display("FAIL reset_done got %b want 0", bus.done); else passed++;
        total++; if (bus.quotient !== '0) $display("FAIL reset_q got %0d want 0", bus.quotient); else passed++;
        total++; if (bus.remainder !== '0) $display("FAIL reset_r got %0d want 0", bus.remainder); else passed++;
        total++; if (bus.div_by_zero !== 1'b0) $display("FAIL reset_dbz got %b want 0", bus.div_by_zero); else passed++;
        rst       = 1'b0;
        bus.start = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int lat, bc;
        run_op(8'd100, 8'd7, lat, bc);
        total++; if (lat != 9) $display("FAIL basic_latency got %0d want 9", lat); else passed++;
        total++; if (bc != 8) $display("FAIL basic_busy_cycles got %0d want 8", bc); else passed++;
        total++; if (bus.quotient !== 8'd14) $display("FAIL basic_q got %0d want 14", bus.quotient); else passed++;
        total++; if (bus.remainder !== 8'd2) $display("FAIL basic_r got %0d want 2", bus.remainder); else passed++;
        total++; if (bus.div_by_zero !== 1'b0) $display("FAIL basic_dbz got %b want 0", bus.div_by_zero); else passed++;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.quotient !== 8'd14 ||
                bus.remainder !== 8'd2)
                $display("FAIL hold_%0d got done=%b busy=%b q=%0d r=%0d want 0 0 14 2",
                         i, bus.done, bus.busy, bus.quotient, bus.remainder);
            else passed++;
        end
    endtask

    task automatic test_back_to_back();
        int lat, bc;
        run_op(8'd255, 8'd1, lat, bc);
        total++; if (bus.quotient !== 8'd255) $display("FAIL b2b_first_q got %0d want 255", bus.quotient); else passed++;
        total++; if (bus.remainder !== 8'd0) $display("FAIL b2b_first_r got %0d want 0", bus.remainder); else passed++;
        // Start raised while still in the DONE cycle of the first operation.
        run_op(8'd5, 8'd9, lat, bc);
        total++; if (lat != 9) $display("FAIL b2b_latency got %0d want 9", lat); else passed++;
        total++; if (bus.quotient !== 8'd0) $display("FAIL b2b_second_q got %0d want 0", bus.quotient); else passed++;
        total++; if (bus.remainder !== 8'd5) $display("FAIL b2b_second_r got %0d want 5", bus.remainder); else passed++;
        tick();
    endtask

    task automatic test_div_zero();
        int lat, bc;
        int dbz_during_run;
        run_op(8'd37, 8'd0, lat, bc);
        total++; if (lat != 1) $display("FAIL dz_latency got %0d want 1", lat); else passed++;
        total++; if (bus.quotient !== 8'd255) $display("FAIL dz_q got %0d want 255", bus.quotient); else passed++;
        total++; if (bus.remainder !== 8'd37) $display("FAIL dz_r got %0d want 37", bus.remainder); else passed++;
        total++; if (bus.div_by_zero !== 1'b1) $display("FAIL dz_flag got %b want 1", bus.div_by_zero); else passed++;
        tick();
        bus.start    = 1'b1;
        bus.dividend = 8'd200;
        bus.divisor  = 8'd16;
        tick();
        bus.start = 1'b0;
        tick();
        dbz_during_run = bus.div_by_zero;
        total++; if (dbz_during_run != 1) $display("FAIL dz_flag_held got %0d want 1", dbz_during_run); else passed++;
        for (int i = 0; i < int'(MaxEdges) && bus.done !== 1'b1; i++) tick();
        total++; if (bus.quotient !== 8'd12) $display("FAIL dz_next_q got %0d want 12", bus.quotient); else passed++;
        total++; if (bus.remainder !== 8'd8) $display("FAIL dz_next_r got %0d want 8", bus.remainder); else passed++;
        total++; if (bus.div_by_zero !== 1'b0) $display("FAIL dz_cleared got %b want 0", bus.div_by_zero); else passed++;
        tick();
    endtask

    task automatic test_start_during_run();
        int lat = 0;
        bus.start    = 1'b1;
        bus.dividend = 8'd100;
        bus.divisor  = 8'd7;
        do begin
            tick();
            lat++;
            if (lat == 1) bus.start = 1'b0;
            if (lat == 3) begin
                bus.start    = 1'b1;
                bus.dividend = 8'd50;
                bus.divisor  = 8'd3;
            end
            if (lat == 4) begin
                bus.start    = 1'b0;
                bus.dividend = 8'd77;
                bus.divisor  = 8'd0;
            end
        end while (bus.done !== 1'b1 && lat < MaxEdges);
        total++; if (lat != 9) $display("FAIL ignore_latency got %0d want 9", lat); else passed++;
        total++; if (bus.quotient !== 8'd14) $display("FAIL ignore_q got %0d want 14", bus.quotient); else passed++;
        total++; if (bus.remainder !== 8'd2) $display("FAIL ignore_r got %0d want 2", bus.remainder); else passed++;
        tick();
    endtask

    task automatic test_reset_mid_run();
        int lat, bc;
        int seen_done = 0;
        bus.start    = 1'b1;
        bus.dividend = 8'd100;
        bus.divisor  = 8'd7;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.quotient !== '0 || bus.remainder !== '0)
            $display("FAIL abort_state got busy=%b done=%b q=%0d r=%0d want 0 0 0 0",
                     bus.busy, bus.done, bus.quotient, bus.remainder);
        else passed++;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.done === 1'b1 || bus.busy === 1'b1) seen_done++;
        end
        total++; if (seen_done != 0) $display("FAIL abort_no_done got %0d active cycles want 0", seen_done); else passed++;
        run_op(8'd9, 8'd4, lat, bc);
        total++; if (lat != 9) $display("FAIL abort_next_latency got %0d want 9", lat); else passed++;
        total++; if (bus.quotient !== 8'd2) $display("FAIL abort_next_q got %0d want 2", bus.quotient); else passed++;
        total++; if (bus.remainder !== 8'd1) $display("FAIL abort_next_r got %0d want 1", bus.remainder); else passed++;
        tick();
    endtask

    task automatic test_random();
        int lat, bc, a, b, eq, er, q, r;
        for (int n = 0; n < 1000; n++) begin
            case ($urandom_range(0, 5))
                0:       a = 0;
                1:       a = 1;
                2:       a = 255;
                default: a = int'($urandom_range(0, 255));
            endcase
            case ($urandom_range(0, 9))
                0:       b = 0;
                1:       b = 1;
                2:       b = 255;
                3:       b = a;
                default: b = int'($urandom_range(1, 255));
            endcase
            run_op(WIDTH'(a), WIDTH'(b), lat, bc);
            eq = ref_q(a, b);
            er = ref_r(a, b);
            q  = int'(bus.quotient);
            r  = int'(bus.remainder);
            total++;
            if (q != eq || r != er)
                $display("FAIL rand_%0d %0d/%0d got q=%0d r=%0d want q=%0d r=%0d", n, a, b, q, r, eq, er);
            else passed++;
            total++;
            if (lat != ((b == 0) ? 1 : 9))
                $display("FAIL rand_latency_%0d got %0d want %0d", n, lat, (b == 0) ? 1 : 9);
            else passed++;
            total++;
            if (bus.div_by_zero !== (b == 0))
                $display("FAIL rand_dbz_%0d got %b want %b", n, bus.div_by_zero, b == 0);
            else passed++;
            if (b != 0) begin
                total++;
                if (q * b + r != a || r >= b)
                    $display("FAIL rand_invariant_%0d got q=%0d r=%0d for %0d/%0d", n, q, r, a, b);
                else passed++;
            end
            if ($urandom_range(0, 1) == 1) tick();
        end
    endtask

    initial begin
        rst          = 1'b0;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_div_zero();
        test_start_during_run();
        test_reset_mid_run();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
